// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: 2:1 AXI4-Lite arbiter, one transaction at a time, per-phase watchdog turns a hung slave into SLVERR
module axi_lite_arbiter_2to1 #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int FIXED_PRIO     = 0
) (
   input  logic        clk,
   input  logic        m_areset,
   input  logic [31:0] s0_axi_araddr,
   input  logic [2:0]  s0_axi_arsize,
   input  logic        s0_axi_arvalid,
   output logic        s0_axi_arready,
   output logic [31:0] s0_axi_rdata,
   output logic [1:0]  s0_axi_rresp,
   output logic        s0_axi_rvalid,
   input  logic        s0_axi_rready,
   input  logic [31:0] s0_axi_awaddr,
   input  logic [2:0]  s0_axi_awsize,
   input  logic        s0_axi_awvalid,
   output logic        s0_axi_awready,
   input  logic [31:0] s0_axi_wdata,
   input  logic [3:0]  s0_axi_wstrb,
   input  logic        s0_axi_wvalid,
   output logic        s0_axi_wready,
   output logic [1:0]  s0_axi_bresp,
   output logic        s0_axi_bvalid,
   input  logic        s0_axi_bready,
   input  logic [31:0] s1_axi_araddr,
   input  logic [2:0]  s1_axi_arsize,
   input  logic        s1_axi_arvalid,
   output logic        s1_axi_arready,
   output logic [31:0] s1_axi_rdata,
   output logic [1:0]  s1_axi_rresp,
   output logic        s1_axi_rvalid,
   input  logic        s1_axi_rready,
   input  logic [31:0] s1_axi_awaddr,
   input  logic [2:0]  s1_axi_awsize,
   input  logic        s1_axi_awvalid,
   output logic        s1_axi_awready,
   input  logic [31:0] s1_axi_wdata,
   input  logic [3:0]  s1_axi_wstrb,
   input  logic        s1_axi_wvalid,
   output logic        s1_axi_wready,
   output logic [1:0]  s1_axi_bresp,
   output logic        s1_axi_bvalid,
   input  logic        s1_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arsize,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awsize,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic        busy,
   output logic        grant,
   output logic        timeout_evt
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, ERR} state_t;
   state_t state_q, state_d;
   logic grant_q, grant_d, last_grant_q, last_grant_d, wr_q, wr_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d, evt_q, evt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic pend0, pend1, pick, pick_rd, expire, run, sel0, sel1;
   logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
   logic arv, awv, wv, rrdy, brdy, aw_hs, w_hs;
   logic s_arrdy, s_rv, s_awrdy, s_wrdy, s_bv;
   logic [31:0] s_rdata;
   logic [1:0] s_rresp, s_bresp;
   assign m_axi_araddr = grant_q ? s1_axi_araddr : s0_axi_araddr;
   assign m_axi_arsize = grant_q ? s1_axi_arsize : s0_axi_arsize;
   assign m_axi_awaddr = grant_q ? s1_axi_awaddr : s0_axi_awaddr;
   assign m_axi_awsize = grant_q ? s1_axi_awsize : s0_axi_awsize;
   assign m_axi_wdata  = grant_q ? s1_axi_wdata  : s0_axi_wdata;
   assign m_axi_wstrb  = grant_q ? s1_axi_wstrb  : s0_axi_wstrb;
   assign g_arvalid = grant_q ? s1_axi_arvalid : s0_axi_arvalid;
   assign g_rready  = grant_q ? s1_axi_rready  : s0_axi_rready;
   assign g_awvalid = grant_q ? s1_axi_awvalid : s0_axi_awvalid;
   assign g_wvalid  = grant_q ? s1_axi_wvalid  : s0_axi_wvalid;
   assign g_bready  = grant_q ? s1_axi_bready  : s0_axi_bready;
   assign pend0 = s0_axi_arvalid | s0_axi_awvalid | s0_axi_wvalid;
   assign pend1 = s1_axi_arvalid | s1_axi_awvalid | s1_axi_wvalid;
   assign pick = (pend0 & pend1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q) : pend1;
   assign pick_rd = pick ? s1_axi_arvalid : s0_axi_arvalid;
   assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_grant_d = last_grant_q;
      wr_d = wr_q;
      aw_done_d = aw_done_q;
      w_done_d = w_done_q;
      cnt_d = cnt_q + CW'(1);
      arv = 1'b0;
      awv = 1'b0;
      wv = 1'b0;
      rrdy = 1'b0;
      brdy = 1'b0;
      aw_hs = 1'b0;
      w_hs = 1'b0;
      s_arrdy = 1'b0;
      s_rv = 1'b0;
      s_awrdy = 1'b0;
      s_wrdy = 1'b0;
      s_bv = 1'b0;
      s_rdata = m_axi_rdata;
      s_rresp = m_axi_rresp;
      s_bresp = m_axi_bresp;
      case (state_q)
         IDLE: begin
            rrdy = 1'b1;
            brdy = 1'b1;
            aw_done_d = 1'b0;
            w_done_d = 1'b0;
            if (pend0 | pend1) begin
               grant_d = pick;
               last_grant_d = pick;
               wr_d = ~pick_rd;
               state_d = pick_rd ? RD_ADDR : WR_ADDR;
            end
         end
         RD_ADDR: begin
            arv = g_arvalid;
            s_arrdy = m_axi_arready;
            state_d = (arv & m_axi_arready) ? RD_DATA : expire ? ERR : RD_ADDR;
         end
         RD_DATA: begin
            rrdy = g_rready;
            s_rv = m_axi_rvalid;
            state_d = (m_axi_rvalid & g_rready) ? IDLE : expire ? ERR : RD_DATA;
         end
         WR_ADDR: begin
            awv = g_awvalid & ~aw_done_q;
            wv = g_wvalid & ~w_done_q;
            s_awrdy = m_axi_awready & ~aw_done_q;
            s_wrdy = m_axi_wready & ~w_done_q;
            aw_hs = awv & m_axi_awready;
            w_hs = wv & m_axi_wready;
            aw_done_d = aw_done_q | aw_hs;
            w_done_d = w_done_q | w_hs;
            if (aw_hs | w_hs) cnt_d = '0;
            state_d = (aw_done_d & w_done_d) ? WR_RESP : (expire & ~aw_hs & ~w_hs) ? ERR : WR_ADDR;
         end
         WR_RESP: begin
            brdy = g_bready;
            s_bv = m_axi_bvalid;
            state_d = (m_axi_bvalid & g_bready) ? IDLE : expire ? ERR : WR_RESP;
         end
         ERR: begin
            rrdy = 1'b1;
            brdy = 1'b1;
            s_rv = ~wr_q;
            s_bv = wr_q;
            s_rdata = '0;
            s_rresp = 2'b10;
            s_bresp = 2'b10;
            state_d = (wr_q ? g_bready : g_rready) ? IDLE : ERR;
         end
         default: state_d = IDLE;
      endcase
      // watchdog only runs while waiting on the slave, and restarts per phase
      if (state_d != state_q || state_d == IDLE || state_d == ERR) cnt_d = '0;
      evt_d = (state_d == ERR) && (state_q != ERR);
   end
   always_ff @(posedge clk) begin
      if (m_areset) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_grant_q <= 1'b1;
         wr_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
         cnt_q <= '0;
         evt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_grant_q <= last_grant_d;
         wr_q <= wr_d;
         aw_done_q <= aw_done_d;
         w_done_q <= w_done_d;
         cnt_q <= cnt_d;
         evt_q <= evt_d;
      end
   end
   assign run = ~m_areset;
   assign sel0 = run & ~grant_q;
   assign sel1 = run & grant_q;
   assign m_axi_arvalid = run & arv;
   assign m_axi_awvalid = run & awv;
   assign m_axi_wvalid = run & wv;
   assign m_axi_rready = run & rrdy;
   assign m_axi_bready = run & brdy;
   assign s0_axi_arready = sel0 & s_arrdy;
   assign s0_axi_rvalid = sel0 & s_rv;
   assign s0_axi_awready = sel0 & s_awrdy;
   assign s0_axi_wready = sel0 & s_wrdy;
   assign s0_axi_bvalid = sel0 & s_bv;
   assign s0_axi_rdata = grant_q ? '0 : s_rdata;
   assign s0_axi_rresp = grant_q ? '0 : s_rresp;
   assign s0_axi_bresp = grant_q ? '0 : s_bresp;
   assign s1_axi_arready = sel1 & s_arrdy;
   assign s1_axi_rvalid = sel1 & s_rv;
   assign s1_axi_awready = sel1 & s_awrdy;
   assign s1_axi_wready = sel1 & s_wrdy;
   assign s1_axi_bvalid = sel1 & s_bv;
   assign s1_axi_rdata = grant_q ? s_rdata : '0;
   assign s1_axi_rresp = grant_q ? s_rresp : '0;
   assign s1_axi_bresp = grant_q ? s_bresp : '0;
   assign busy = state_q != IDLE;
   assign grant = grant_q;
   assign timeout_evt = evt_q;
endmodule
